// File: rtl/ipm_warp_pipe_if.sv
// Pixel stream bundle shared by the camera side and the frame-buffer side
// of the inverse-perspective warp.
//   sof   : first pixel of a frame (qualified by we)
//   we    : pixel valid
//   data  : pixel value
//   line  : y coordinate
//   pixel : x coordinate
// master drives the stream, slave receives it.
interface ipm_warp_pipe_if #(
    parameter int CAM_DATA_WIDTH = 12,
    parameter int CAM_LINE       = 9,
    parameter int CAM_PIXEL      = 10
) ();
    logic                      sof;
    logic                      we;
    logic [CAM_DATA_WIDTH-1:0] data;
    logic [CAM_LINE-1:0]       line;
    logic [CAM_PIXEL-1:0]      pixel;

    modport master (output sof, we, data, line, pixel);
    modport slave  (input  sof, we, data, line, pixel);
endinterface

// File: rtl/ipm_warp_pipe.sv
// ipm_warp_pipe: camera-to-bird's-eye projective warp.
// Each valid camera pixel (x,y) is mapped through a runtime-loaded 3x3
// homography, [X Y W] = [x y 1] * T, and emitted at (X/W, Y/W). 1/W comes
// from an external LUT (index out, result back one cycle later). Fixed
// 8-cycle latency in both transform and bypass modes, one pixel per clock.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_mode            00 bypass, else transform; latched on sof
//   in_bus (slave)    camera pixel stream
//   cfg_we/addr/data  staging writes: 0-8 T11..T33, 9 width, 10 depth
//   cfg_commit        request staging -> active at next sof
//   o_cfg_pending     commit requested but not yet applied
//   o_lut_idx         reciprocal LUT index, unsigned Q4.8 of W
//   i_lut_inv         signed reciprocal, Q(INV_FRAC)
//   out_bus (master)  warped pixel stream
//   o_imag_*          active output frame geometry / resize flag
//   o_drop_cnt        saturating per-frame count of rejected pixels
module ipm_warp_pipe #(
    parameter int CAM_DATA_WIDTH = 12,
    parameter int CAM_LINE       = 9,
    parameter int CAM_PIXEL      = 10,
    parameter int COEF_WIDTH     = 25,
    parameter int FRAC           = 12,
    parameter int INV_WIDTH      = 12,
    parameter int INV_FRAC       = 8,
    parameter int DEF_WIDTH      = 160,
    parameter int DEF_DEPTH      = 160
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    i_mode,
    ipm_warp_pipe_if.slave                in_bus,
    input  logic                          cfg_we,
    input  logic [3:0]                    cfg_addr,
    input  logic [COEF_WIDTH-1:0]         cfg_data,
    input  logic                          cfg_commit,
    output logic                          o_cfg_pending,
    output logic [11:0]                   o_lut_idx,
    input  logic signed [INV_WIDTH-1:0]   i_lut_inv,
    ipm_warp_pipe_if.master               out_bus,
    output logic [CAM_PIXEL-1:0]          o_imag_width,
    output logic [CAM_LINE-1:0]           o_imag_depth,
    output logic                          o_imag_resized,
    output logic [15:0]                   o_drop_cnt
);

    localparam int SUM_W = COEF_WIDTH + CAM_PIXEL + 3;
    localparam int MUL_W = COEF_WIDTH + INV_WIDTH;
    localparam int IPOS  = FRAC + INV_FRAC;
    localparam int INT_W = MUL_W - IPOS;
    localparam int NSTG  = 7;

    localparam logic signed [COEF_WIDTH-1:0] ONE   = COEF_WIDTH'(1 << FRAC);
    localparam logic signed [COEF_WIDTH-1:0] W_SAT = COEF_WIDTH'(16 << FRAC);

    // ---------------- configuration ----------------
    logic signed [COEF_WIDTH-1:0] stg_coef [9];
    logic signed [COEF_WIDTH-1:0] act_coef [9];
    logic [CAM_PIXEL-1:0]         stg_width, act_width, chk_width;
    logic [CAM_LINE-1:0]          stg_depth, act_depth, chk_depth;
    logic                         act_byp;
    logic                         sof_in;
    logic                         eff_byp;

    assign sof_in  = in_bus.sof & in_bus.we;
    assign eff_byp = sof_in ? (i_mode == 2'b00) : act_byp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < 9; j++) begin
                stg_coef[j] <= (j % 4 == 0) ? ONE : '0;
                act_coef[j] <= (j % 4 == 0) ? ONE : '0;
            end
            stg_width     <= CAM_PIXEL'(DEF_WIDTH);
            act_width     <= CAM_PIXEL'(DEF_WIDTH);
            stg_depth     <= CAM_LINE'(DEF_DEPTH);
            act_depth     <= CAM_LINE'(DEF_DEPTH);
            act_byp       <= 1'b0;
            o_cfg_pending <= 1'b0;
        end else begin
            // Apply uses the staging contents from before this cycle's write.
            if (sof_in) act_byp <= (i_mode == 2'b00);
            if (sof_in && (o_cfg_pending || cfg_commit)) begin
                for (int unsigned j = 0; j < 9; j++) act_coef[j] <= stg_coef[j];
                act_width     <= stg_width;
                act_depth     <= stg_depth;
                o_cfg_pending <= 1'b0;
            end else if (cfg_commit) begin
                o_cfg_pending <= 1'b1;
            end
            if (cfg_we) begin
                for (int unsigned j = 0; j < 9; j++)
                    if (cfg_addr == 4'(j)) stg_coef[j] <= cfg_data;
                if (cfg_addr == 4'd9)  stg_width <= cfg_data[CAM_PIXEL-1:0];
                if (cfg_addr == 4'd10) stg_depth <= cfg_data[CAM_LINE-1:0];
            end
        end
    end

    assign o_imag_width   = act_byp ? '1 : act_width;
    assign o_imag_depth   = act_byp ? '1 : act_depth;
    assign o_imag_resized = ~act_byp;

    // ---------------- control pipeline (stages 1..7) ----------------
    logic we_d  [NSTG];
    logic sof_d [NSTG];
    logic byp_d [NSTG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSTG; i++) begin
                we_d[i]  <= 1'b0;
                sof_d[i] <= 1'b0;
                byp_d[i] <= 1'b0;
            end
            chk_width <= CAM_PIXEL'(DEF_WIDTH);
            chk_depth <= CAM_LINE'(DEF_DEPTH);
        end else begin
            we_d[0]  <= in_bus.we;
            sof_d[0] <= in_bus.sof;
            byp_d[0] <= eff_byp;
            for (int unsigned i = 1; i < NSTG; i++) begin
                we_d[i]  <= we_d[i-1];
                sof_d[i] <= sof_d[i-1];
                byp_d[i] <= byp_d[i-1];
            end
            // Bounds follow the sof pixel into the final stage so pixels of
            // the previous frame still in flight keep the old geometry.
            if (we_d[5] && sof_d[5]) begin
                chk_width <= act_width;
                chk_depth <= act_depth;
            end
        end
    end

    // ---------------- datapath ----------------
    logic [CAM_DATA_WIDTH-1:0]  data_d [NSTG];
    logic [CAM_PIXEL-1:0]       bx     [NSTG];
    logic [CAM_LINE-1:0]        by     [NSTG];
    logic signed [SUM_W-1:0]    s1_x, s1_y;
    logic signed [SUM_W-1:0]    s2_p [9];
    logic signed [SUM_W-1:0]    s3_a [3];
    logic signed [SUM_W-1:0]    s3_b [3];
    logic signed [SUM_W-1:0]    s4   [3];
    logic signed [COEF_WIDTH-1:0] s5_x, s5_y, s6_x, s6_y;
    logic                       s5_wneg, s6_wneg, s7_wneg;
    logic signed [MUL_W-1:0]    s7_px, s7_py;

    logic signed [COEF_WIDTH-1:0] w_t;
    logic [11:0]                  lut_idx_nxt;
    logic                         w_le0;

    always_comb begin
        w_t         = s4[2][COEF_WIDTH-1:0];
        w_le0       = w_t[COEF_WIDTH-1] || (w_t == '0);
        lut_idx_nxt = (!w_t[COEF_WIDTH-1] && (w_t >= W_SAT)) ? '1 : w_t[FRAC+3:FRAC-8];
    end

    always_ff @(posedge clk) begin
        data_d[0] <= in_bus.data;
        bx[0]     <= in_bus.pixel;
        by[0]     <= in_bus.line;
        for (int unsigned i = 1; i < NSTG; i++) begin
            data_d[i] <= data_d[i-1];
            bx[i]     <= bx[i-1];
            by[i]     <= by[i-1];
        end
        s1_x <= {{(SUM_W-CAM_PIXEL){1'b0}}, in_bus.pixel};
        s1_y <= {{(SUM_W-CAM_LINE){1'b0}}, in_bus.line};
        for (int unsigned c = 0; c < 3; c++) begin
            s2_p[c]   <= s1_x * SUM_W'(act_coef[c]);
            s2_p[3+c] <= s1_y * SUM_W'(act_coef[3+c]);
            s2_p[6+c] <= SUM_W'(act_coef[6+c]);
            s3_a[c]   <= s2_p[c] + s2_p[3+c];
            s3_b[c]   <= s2_p[6+c];
            s4[c]     <= s3_a[c] + s3_b[c];
        end
        s5_x    <= s4[0][COEF_WIDTH-1:0];
        s5_y    <= s4[1][COEF_WIDTH-1:0];
        s5_wneg <= w_le0;
        s6_x    <= s5_x;
        s6_y    <= s5_y;
        s6_wneg <= s5_wneg;
        s7_px   <= MUL_W'(s6_x) * MUL_W'(i_lut_inv);
        s7_py   <= MUL_W'(s6_y) * MUL_W'(i_lut_inv);
        s7_wneg <= s6_wneg;
    end

    // ---------------- stage 8: reject / emit ----------------
    logic [INT_W-1:0] x_int, y_int;
    logic             drop_hit, drop;

    always_comb begin
        x_int    = s7_px[MUL_W-1:IPOS];
        y_int    = s7_py[MUL_W-1:IPOS];
        drop_hit = s7_wneg || s7_px[MUL_W-1] || s7_py[MUL_W-1]
                   || (x_int >= INT_W'(chk_width)) || (y_int >= INT_W'(chk_depth));
        drop     = we_d[6] && !byp_d[6] && drop_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_lut_idx     <= '0;
            out_bus.we    <= 1'b0;
            out_bus.sof   <= 1'b0;
            out_bus.data  <= '0;
            out_bus.pixel <= '0;
            out_bus.line  <= '0;
            o_drop_cnt    <= '0;
        end else begin
            o_lut_idx    <= lut_idx_nxt;
            out_bus.sof  <= we_d[6] & sof_d[6];
            out_bus.data <= data_d[6];
            if (!we_d[6] || drop) begin
                out_bus.we    <= 1'b0;
                out_bus.pixel <= '0;
                out_bus.line  <= '0;
            end else if (byp_d[6]) begin
                out_bus.we    <= 1'b1;
                out_bus.pixel <= bx[6];
                out_bus.line  <= by[6];
            end else begin
                out_bus.we    <= 1'b1;
                out_bus.pixel <= x_int[CAM_PIXEL-1:0];
                out_bus.line  <= y_int[CAM_LINE-1:0];
            end
            // The sof pixel restarts the count, including its own drop.
            if (we_d[6] && sof_d[6])
                o_drop_cnt <= drop ? 16'd1 : '0;
            else if (drop && (o_drop_cnt != '1))
                o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{s4[0][SUM_W-1:COEF_WIDTH], s4[1][SUM_W-1:COEF_WIDTH],
                           s4[2][SUM_W-1:COEF_WIDTH],
                           s7_px[IPOS-1:0], s7_py[IPOS-1:0]};

endmodule

// File: tb/tb_ipm_warp_pipe.sv
// Directed bench for ipm_warp_pipe with a scoreboard queue: every driven
// cycle pushes its expected output, which is popped 8 cycles later.
module tb_ipm_warp_pipe;
    localparam int DW = 12;
    localparam int LW = 9;
    localparam int PW = 10;
    localparam int CW = 25;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        i_mode = '0;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic [CW-1:0]     cfg_data = '0;
    logic              cfg_commit = 1'b0;
    logic              o_cfg_pending;
    logic [11:0]       o_lut_idx;
    logic signed [11:0] lut_inv = '0;
    logic [PW-1:0]     o_imag_width;
    logic [LW-1:0]     o_imag_depth;
    logic              o_imag_resized;
    logic [15:0]       o_drop_cnt;

    ipm_warp_pipe_if #(.CAM_DATA_WIDTH(DW), .CAM_LINE(LW), .CAM_PIXEL(PW)) in_bus ();
    ipm_warp_pipe_if #(.CAM_DATA_WIDTH(DW), .CAM_LINE(LW), .CAM_PIXEL(PW)) out_bus ();

    ipm_warp_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_mode         (i_mode),
        .in_bus         (in_bus),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .o_cfg_pending  (o_cfg_pending),
        .o_lut_idx      (o_lut_idx),
        .i_lut_inv      (lut_inv),
        .out_bus        (out_bus),
        .o_imag_width   (o_imag_width),
        .o_imag_depth   (o_imag_depth),
        .o_imag_resized (o_imag_resized),
        .o_drop_cnt     (o_drop_cnt)
    );

    // 1/w lookup model: Q4.8 index in, Q.8 reciprocal out, one cycle later.
    function automatic logic signed [11:0] inv_of(input logic [11:0] idx);
        int v;
        if (idx == 12'd0) v = 2047;
        else v = 65536 / int'(idx);
        if (v > 2047) v = 2047;
        return 12'(v);
    endfunction

    always @(posedge clk) lut_inv <= inv_of(o_lut_idx);

    typedef struct {
        bit vsof;
        bit we;
        bit drop;
        int pixel;
        int line;
        int data;
    } exp_t;

    exp_t   sbq[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    longint t_act[9];
    longint t_stg[9];
    int     w_act, d_act, w_stg, d_stg;
    bit     pend, byp_act;
    int     cnt_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic longint trunc25(input longint v);
        longint m;
        m = v & ((64'sd1 << 25) - 1);
        if (m[24]) m = m - (64'sd1 << 25);
        return m;
    endfunction

    function automatic exp_t model(input bit we, input bit sof, input bit byp,
                                   input int x, input int y, input int data);
        exp_t   e;
        longint xv, yv, wv, px, py, idx, inv;
        e.vsof = we && sof;
        e.data = data;
        e.we = 1'b0; e.drop = 1'b0; e.pixel = 0; e.line = 0;
        if (!we) return e;
        if (byp) begin
            e.we = 1'b1; e.pixel = x; e.line = y;
            return e;
        end
        xv = trunc25(x * t_act[0] + y * t_act[3] + t_act[6]);
        yv = trunc25(x * t_act[1] + y * t_act[4] + t_act[7]);
        wv = trunc25(x * t_act[2] + y * t_act[5] + t_act[8]);
        if (wv >= (64'sd16 << 12)) idx = 4095;
        else idx = (wv >>> 4) & 4095;
        inv = longint'(inv_of(12'(idx)));
        px = xv * inv;
        py = yv * inv;
        if (wv <= 0 || px < 0 || py < 0 || (px >>> 20) >= w_act || (py >>> 20) >= d_act) begin
            e.drop = 1'b1;
        end else begin
            e.we = 1'b1;
            e.pixel = int'(px >>> 20);
            e.line  = int'(py >>> 20);
        end
        return e;
    endfunction

    task automatic step(input bit we, input bit sof, input int x, input int y, input int data);
        exp_t e;
        bit   eb;
        in_bus.we    = we;
        in_bus.sof   = sof;
        in_bus.pixel = PW'(x);
        in_bus.line  = LW'(y);
        in_bus.data  = DW'(data);
        eb = byp_act;
        if (we && sof) begin
            byp_act = (i_mode == 2'b00);
            eb = byp_act;
            if (pend || cfg_commit) begin
                t_act = t_stg; w_act = w_stg; d_act = d_stg; pend = 1'b0;
            end
        end else if (cfg_commit) begin
            pend = 1'b1;
        end
        if (cfg_we) begin
            if (cfg_addr <= 4'd8) t_stg[cfg_addr] = longint'($signed(cfg_data));
            if (cfg_addr == 4'd9)  w_stg = int'(cfg_data[PW-1:0]);
            if (cfg_addr == 4'd10) d_stg = int'(cfg_data[LW-1:0]);
        end
        sbq.push_back(model(we, sof, eb, x, y, data));
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        in_bus.we = 1'b0;
        in_bus.sof = 1'b0;
        e = sbq.pop_front();
        chk("o_we", 64'(out_bus.we), 64'(e.we));
        chk("o_sof", 64'(out_bus.sof), 64'(e.vsof));
        if (e.we) begin
            chk("o_pixel", 64'(out_bus.pixel), 64'(e.pixel));
            chk("o_line", 64'(out_bus.line), 64'(e.line));
            chk("o_data", 64'(out_bus.data), 64'(e.data));
        end
        if (e.drop) begin
            chk("drop_pixel", 64'(out_bus.pixel), 64'd0);
            chk("drop_line", 64'(out_bus.line), 64'd0);
        end
        if (e.vsof) cnt_m = e.drop ? 1 : 0;
        else if (e.drop && cnt_m < 65535) cnt_m++;
        chk("o_drop_cnt", 64'(o_drop_cnt), 64'(cnt_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = CW'(data);
        step(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        exp_t d;
        rst_n = 1'b0;
        in_bus.we = 1'b0;
        in_bus.sof = 1'b0;
        #2;
        chk("rst_pending", 64'(o_cfg_pending), 64'd0);
        chk("rst_we", 64'(out_bus.we), 64'd0);
        chk("rst_sof", 64'(out_bus.sof), 64'd0);
        chk("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
        chk("rst_lut_idx", 64'(o_lut_idx), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 9; j++) begin
            t_act[j] = (j % 4 == 0) ? 4096 : 0;
            t_stg[j] = t_act[j];
        end
        w_act = 160; d_act = 160; w_stg = 160; d_stg = 160;
        pend = 1'b0; byp_act = 1'b0; cnt_m = 0;
        sbq.delete();
        d.vsof = 0; d.we = 0; d.drop = 0; d.pixel = 0; d.line = 0; d.data = 0;
        for (int j = 0; j < 7; j++) sbq.push_back(d);
    endtask

    initial begin
        in_bus.we = 1'b0; in_bus.sof = 1'b0;
        in_bus.pixel = '0; in_bus.line = '0; in_bus.data = '0;
        #3;
        do_reset();
        chk("rst_width", 64'(o_imag_width), 64'd160);
        chk("rst_depth", 64'(o_imag_depth), 64'd160);
        chk("rst_resized", 64'(o_imag_resized), 64'd1);

        // Identity transform, including width/depth boundary pixels.
        i_mode = 2'b01;
        step(1'b1, 1'b1, 10, 20, 'h123);
        step(1'b1, 1'b0, 170, 5, 'h055);
        step(1'b1, 1'b0, 159, 159, 1);
        step(1'b1, 1'b0, 0, 160, 2);
        idle(8);
        chk("frame1_drops", 64'(o_drop_cnt), 64'd2);

        // Bypass.
        i_mode = 2'b00;
        step(1'b1, 1'b1, 639, 479, 'hABC);
        idle(8);
        chk("byp_resized", 64'(o_imag_resized), 64'd0);
        chk("byp_width", 64'(o_imag_width), 64'd1023);
        chk("byp_depth", 64'(o_imag_depth), 64'd511);

        // Mid-frame commit waits for the next sof.
        i_mode = 2'b01;
        step(1'b1, 1'b1, 5, 5, 1);
        cfg_write(0, 2 << 12);
        cfg_commit = 1'b1;
        step(1'b1, 1'b0, 30, 7, 3);
        chk("pending_set", 64'(o_cfg_pending), 64'd1);
        step(1'b1, 1'b0, 31, 7, 4);
        idle(8);
        chk("pending_held", 64'(o_cfg_pending), 64'd1);
        step(1'b1, 1'b1, 30, 7, 5);
        chk("pending_clr", 64'(o_cfg_pending), 64'd0);
        idle(8);

        // W = -1: every pixel rejected; commit coincides with sof.
        cfg_write(0, 0);
        cfg_write(4, 0);
        cfg_write(8, -4096);
        cfg_commit = 1'b1;
        step(1'b1, 1'b1, 0, 0, 0);
        for (int i = 1; i < 100; i++) step(1'b1, 1'b0, i % 160, i % 100, i);
        idle(8);
        chk("neg_w_drops", 64'(o_drop_cnt), 64'd100);
        step(1'b1, 1'b1, 1, 1, 1);
        idle(8);
        chk("neg_w_newframe", 64'(o_drop_cnt), 64'd1);

        // Identity with 200x120 frame, 640 pixels with random gaps.
        cfg_write(0, 4096);
        cfg_write(4, 4096);
        cfg_write(8, 4096);
        cfg_write(9, 200);
        cfg_write(10, 120);
        cfg_commit = 1'b1;
        for (int n = 0; n < 640; n++) begin
            while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 0, 0, 0);
            step(1'b1, n == 0, n % 200, n % 120, n);
        end
        step(1'b1, 1'b0, 200, 0, 7);
        step(1'b1, 1'b0, 199, 119, 8);
        idle(8);
        chk("burst_width", 64'(o_imag_width), 64'd200);
        chk("burst_drops", 64'(o_drop_cnt), 64'd1);

        // Reset with pixels in flight and a pending commit.
        cfg_commit = 1'b1;
        step(1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10 + i, 10, i);
        chk("pre_rst_pending", 64'(o_cfg_pending), 64'd1);
        do_reset();
        idle(10);
        step(1'b1, 1'b1, 7, 8, 'h321);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
